// File: rtl/axi_isolate_pkg.sv
// Shared types and helpers for the AXI slice isolation controller.
package axi_isolate_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    ISOLATED = 2'd2
  } isolate_state_e;

  localparam int DEFAULT_MAX_OUTSTANDING = 16;

  // True when a saturating up/down counter will read zero after this cycle's events.
  function automatic logic cnt_next_zero(input logic is_zero, input logic is_one,
                                         input logic inc, input logic dec);
    return (is_zero & (~inc | dec)) | (is_one & dec & ~inc);
  endfunction

endpackage

// File: rtl/axi_outstanding_cnt.sv
// Outstanding-burst counter, saturating at 0 and MAX; increment and decrement together hold the value.
module axi_outstanding_cnt
  import axi_isolate_pkg::*;
#(
  parameter int MAX       = DEFAULT_MAX_OUTSTANDING,
  parameter int CNT_WIDTH = $clog2(MAX + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc_i,
  input  logic                 dec_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 full_o,
  output logic                 empty_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign full_o  = (cnt_q == CNT_WIDTH'(MAX));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i & ~dec_i & ~full_o) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (dec_i & ~inc_i & ~empty_o) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_isolate_ctrl.sv
// Isolation sequencer for one AXI slave slice: gates AW/AR, drains in-flight bursts, then isolates.
// Optional drain timeout enabled by defining AXI_ISOLATE_TIMEOUT_EN.
module axi_isolate_ctrl
  import axi_isolate_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1),
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 isolate_req_i,
  output logic                 isolate_ack_o,
  output logic                 isolate_o,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  output logic                 ar_valid_o,
  input  logic                 ar_ready_i,
  input  logic                 b_valid_i,
  input  logic                 b_ready_i,
  input  logic                 r_valid_i,
  input  logic                 r_ready_i,
  input  logic                 r_last_i,
  output logic [CNT_WIDTH-1:0] wr_cnt_o,
  output logic [CNT_WIDTH-1:0] rd_cnt_o,
  output logic                 timeout_o
);

  isolate_state_e state_q, state_d;
  logic iso_q, iso_d;
  logic aw_block, ar_block;
  logic wr_inc, wr_dec, rd_inc, rd_dec;
  logic wr_full, wr_empty, rd_full, rd_empty;
  logic wr_zero_nxt, rd_zero_nxt, all_zero_nxt;
  logic aw_pend, ar_pend;
  logic drain_expired, cnt_clr;

  assign aw_block   = (state_q != RUN) | wr_full;
  assign ar_block   = (state_q != RUN) | rd_full;
  assign aw_valid_o = aw_valid_i & ~aw_block;
  assign aw_ready_o = aw_ready_i & ~aw_block;
  assign ar_valid_o = ar_valid_i & ~ar_block;
  assign ar_ready_o = ar_ready_i & ~ar_block;

  assign wr_inc = aw_valid_o & aw_ready_i;
  assign wr_dec = b_valid_i & b_ready_i;
  assign rd_inc = ar_valid_o & ar_ready_i;
  assign rd_dec = r_valid_i & r_ready_i & r_last_i;

  // An address already presented upstream must finish before gating starts.
  assign aw_pend = aw_valid_i & ~aw_ready_i;
  assign ar_pend = ar_valid_i & ~ar_ready_i;

  assign wr_zero_nxt  = cnt_next_zero(wr_empty, wr_cnt_o == CNT_WIDTH'(1), wr_inc, wr_dec);
  assign rd_zero_nxt  = cnt_next_zero(rd_empty, rd_cnt_o == CNT_WIDTH'(1), rd_inc, rd_dec);
  assign all_zero_nxt = wr_zero_nxt & rd_zero_nxt;

  assign cnt_clr = (state_q == DRAIN) & isolate_req_i & ~all_zero_nxt & drain_expired;

  axi_outstanding_cnt #(
    .MAX       (MAX_OUTSTANDING),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_wr_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (wr_inc),
    .dec_i   (wr_dec),
    .clr_i   (cnt_clr),
    .cnt_o   (wr_cnt_o),
    .full_o  (wr_full),
    .empty_o (wr_empty)
  );

  axi_outstanding_cnt #(
    .MAX       (MAX_OUTSTANDING),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_rd_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (rd_inc),
    .dec_i   (rd_dec),
    .clr_i   (cnt_clr),
    .cnt_o   (rd_cnt_o),
    .full_o  (rd_full),
    .empty_o (rd_empty)
  );

`ifdef AXI_ISOLATE_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             timeout_q, timeout_d;

  // tmr_q holds the number of DRAIN cycles already spent; zero on every DRAIN entry.
  assign tmr_d         = (state_q == DRAIN) ? tmr_q + TMR_W'(1) : '0;
  assign drain_expired = (state_q == DRAIN) & (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign timeout_d     = timeout_q | cnt_clr;
  assign timeout_o     = timeout_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign drain_expired = 1'b0;
  // Constant 0; the parameter is referenced so every build shares one port/parameter set.
  assign timeout_o     = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (isolate_req_i & ~aw_pend & ~ar_pend) state_d = DRAIN;
      end
      DRAIN: begin
        if (~isolate_req_i)     state_d = RUN;
        else if (all_zero_nxt)  state_d = ISOLATED;
        else if (drain_expired) state_d = ISOLATED;
      end
      ISOLATED: begin
        if (~isolate_req_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign iso_d         = (state_d == ISOLATED);
  assign isolate_o     = iso_q;
  assign isolate_ack_o = iso_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      iso_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iso_q   <= iso_d;
    end
  end

endmodule

// File: tb/tb_axi_isolate_ctrl.sv
// Bench for axi_isolate_ctrl: directed scenarios plus random traffic against a transaction-level model.
module tb_axi_isolate_ctrl;

  localparam int MAXO = 16;
  localparam int CW   = $clog2(MAXO + 1);
  localparam int TO   = 8;
  localparam int M_RUN = 0, M_DRAIN = 1, M_ISO = 2;

  logic clk_i = 1'b0;
  logic rst_i;
  logic isolate_req_i, aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i;
  logic b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i;
  logic isolate_ack_o, isolate_o, aw_ready_o, aw_valid_o, ar_ready_o, ar_valid_o, timeout_o;
  logic [CW-1:0] wr_cnt_o, rd_cnt_o;

  always #5 clk_i = ~clk_i;

  axi_isolate_ctrl #(
    .MAX_OUTSTANDING (MAXO),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .isolate_req_i (isolate_req_i),
    .isolate_ack_o (isolate_ack_o),
    .isolate_o     (isolate_o),
    .aw_valid_i    (aw_valid_i),
    .aw_ready_o    (aw_ready_o),
    .aw_valid_o    (aw_valid_o),
    .aw_ready_i    (aw_ready_i),
    .ar_valid_i    (ar_valid_i),
    .ar_ready_o    (ar_ready_o),
    .ar_valid_o    (ar_valid_o),
    .ar_ready_i    (ar_ready_i),
    .b_valid_i     (b_valid_i),
    .b_ready_i     (b_ready_i),
    .r_valid_i     (r_valid_i),
    .r_ready_i     (r_ready_i),
    .r_last_i      (r_last_i),
    .wr_cnt_o      (wr_cnt_o),
    .rd_cnt_o      (rd_cnt_o),
    .timeout_o     (timeout_o)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: outstanding burst counts and the controller's phase.
  int m_mode, m_wr, m_rd, m_dcyc, m_to;
  int nx_mode, nx_wr, nx_rd, nx_dcyc, nx_to;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN; m_wr = 0; m_rd = 0; m_dcyc = 0; m_to = 0;
  endtask

  task automatic model_check();
    int gate_w, gate_r;
    gate_w = (m_mode != M_RUN) || (m_wr == MAXO);
    gate_r = (m_mode != M_RUN) || (m_rd == MAXO);
    check_val("aw_valid_o", aw_valid_o, aw_valid_i && (gate_w == 0));
    check_val("aw_ready_o", aw_ready_o, aw_ready_i && (gate_w == 0));
    check_val("ar_valid_o", ar_valid_o, ar_valid_i && (gate_r == 0));
    check_val("ar_ready_o", ar_ready_o, ar_ready_i && (gate_r == 0));
    check_val("wr_cnt_o", wr_cnt_o, m_wr);
    check_val("rd_cnt_o", rd_cnt_o, m_rd);
    check_val("isolate_o", isolate_o, m_mode == M_ISO);
    check_val("isolate_ack_o", isolate_ack_o, m_mode == M_ISO);
    check_val("timeout_o", timeout_o, m_to);
  endtask

  task automatic model_next();
    int open_w, open_r, wi, wd, ri, rdn;
    open_w = (m_mode == M_RUN) && (m_wr < MAXO);
    open_r = (m_mode == M_RUN) && (m_rd < MAXO);
    wi  = (open_w && aw_valid_i && aw_ready_i) ? 1 : 0;
    wd  = (b_valid_i && b_ready_i) ? 1 : 0;
    ri  = (open_r && ar_valid_i && ar_ready_i) ? 1 : 0;
    rdn = (r_valid_i && r_ready_i && r_last_i) ? 1 : 0;
    nx_wr = m_wr + wi - wd; if (nx_wr < 0) nx_wr = 0;
    nx_rd = m_rd + ri - rdn; if (nx_rd < 0) nx_rd = 0;
    nx_mode = m_mode; nx_dcyc = m_dcyc; nx_to = m_to;
    if (m_mode == M_RUN) begin
      if (isolate_req_i && !(aw_valid_i && !aw_ready_i) && !(ar_valid_i && !ar_ready_i)) begin
        nx_mode = M_DRAIN; nx_dcyc = 0;
      end
    end else if (m_mode == M_DRAIN) begin
      nx_dcyc = m_dcyc + 1;
      if (!isolate_req_i) nx_mode = M_RUN;
      else if (nx_wr == 0 && nx_rd == 0) nx_mode = M_ISO;
`ifdef AXI_ISOLATE_TIMEOUT_EN
      else if (nx_dcyc == TO) begin
        nx_mode = M_ISO; nx_to = 1; nx_wr = 0; nx_rd = 0;
      end
`endif
    end else begin
      if (!isolate_req_i) nx_mode = M_RUN;
    end
  endtask

  // One clock cycle; entered and left just after a falling edge with inputs already applied.
  task automatic cyc();
    #1;
    model_check();
    model_next();
    @(posedge clk_i);
    m_mode = nx_mode; m_wr = nx_wr; m_rd = nx_rd; m_dcyc = nx_dcyc; m_to = nx_to;
    @(negedge clk_i);
  endtask

  task automatic idle_bus();
    aw_valid_i = 0; aw_ready_i = 0; ar_valid_i = 0; ar_ready_i = 0;
    b_valid_i = 0; b_ready_i = 0; r_valid_i = 0; r_ready_i = 0; r_last_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    model_reset();
    model_check();
    check_val("rst_isolate_o", isolate_o, 0);
    check_val("rst_ack", isolate_ack_o, 0);
    check_val("rst_wr_cnt", wr_cnt_o, 0);
    check_val("rst_rd_cnt", rd_cnt_o, 0);
    check_val("rst_timeout", timeout_o, 0);
    idle_bus();
    isolate_req_i = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    int bias;
    rst_i = 1'b1;
    isolate_req_i = 0;
    idle_bus();
    do_reset();

    // Idle bus request: ack two cycles after req, release one cycle after drop.
    isolate_req_i = 1; cyc();
    check_val("idle_iso_c1", isolate_o, 0);
    cyc();
    check_val("idle_iso_c2", isolate_o, 1);
    check_val("idle_ack_c2", isolate_ack_o, 1);
    cyc();
    isolate_req_i = 0; cyc();
    check_val("idle_release", isolate_ack_o, 0);

    // Three writes and two reads outstanding, then drain.
    aw_valid_i = 1; aw_ready_i = 1; ar_valid_i = 1; ar_ready_i = 1;
    cyc(); cyc();
    ar_valid_i = 0; cyc();
    aw_valid_i = 0;
    check_val("burst_wr3", wr_cnt_o, 3);
    check_val("burst_rd2", rd_cnt_o, 2);
    isolate_req_i = 1; cyc();
    aw_valid_i = 1; ar_valid_i = 1; #1;
    check_val("burst_aw_gated", aw_valid_o, 0);
    check_val("burst_ar_gated", ar_valid_o, 0);
    aw_valid_i = 0; ar_valid_i = 0;
    b_valid_i = 1; b_ready_i = 1; r_valid_i = 1; r_ready_i = 1; r_last_i = 1;
    cyc();
    check_val("drain_wr2", wr_cnt_o, 2);
    check_val("drain_rd1", rd_cnt_o, 1);
    cyc();
    r_valid_i = 0;
    check_val("drain_no_iso", isolate_o, 0);
    cyc();
    b_valid_i = 0;
    check_val("drain_wr0", wr_cnt_o, 0);
    check_val("drain_iso", isolate_o, 1);
    isolate_req_i = 0; cyc();
    idle_bus();

    // Fill the write side to the cap.
    aw_valid_i = 1; aw_ready_i = 1;
    repeat (MAXO) cyc();
    check_val("full_cnt", wr_cnt_o, MAXO);
    check_val("full_aw_ready", aw_ready_o, 0);
    b_valid_i = 1; b_ready_i = 1; cyc();
    check_val("full_b_dec", wr_cnt_o, MAXO - 1);
    cyc();
    check_val("same_cycle_hold", wr_cnt_o, MAXO - 1);
    aw_valid_i = 0;
    repeat (MAXO) cyc();
    check_val("dec_at_zero", wr_cnt_o, 0);
    idle_bus();

    // AW stalled when req rises: FSM waits for the handshake.
    aw_valid_i = 1; aw_ready_i = 0; isolate_req_i = 1;
    cyc(); cyc();
    check_val("pend_aw_valid", aw_valid_o, 1);
    aw_ready_i = 1; cyc();
    aw_valid_i = 0; aw_ready_i = 0;
    check_val("pend_counted", wr_cnt_o, 1);
    aw_valid_i = 1; #1;
    check_val("pend_then_gated", aw_valid_o, 0);
    aw_valid_i = 0;
    b_valid_i = 1; b_ready_i = 1; cyc();
    b_valid_i = 0;
    check_val("pend_iso", isolate_o, 1);
    isolate_req_i = 0; cyc();
    idle_bus();

    // Abort during drain with one read outstanding.
    ar_valid_i = 1; ar_ready_i = 1; cyc();
    ar_valid_i = 0; isolate_req_i = 1; cyc();
    cyc();
    isolate_req_i = 0; cyc();
    check_val("abort_no_iso", isolate_o, 0);
    ar_valid_i = 1; ar_ready_i = 0; #1;
    check_val("abort_ar_open", ar_valid_o, 1);
    ar_valid_i = 0;
    r_valid_i = 1; r_ready_i = 1; r_last_i = 1; cyc();
    idle_bus();

`ifdef AXI_ISOLATE_TIMEOUT_EN
    // Write never answered: forced isolation after TO drain cycles.
    aw_valid_i = 1; aw_ready_i = 1; cyc();
    idle_bus();
    isolate_req_i = 1; cyc();
    repeat (TO - 1) cyc();
    check_val("to_not_yet", isolate_o, 0);
    cyc();
    check_val("to_iso", isolate_o, 1);
    check_val("to_flag", timeout_o, 1);
    check_val("to_wr_clr", wr_cnt_o, 0);
    isolate_req_i = 0; cyc();
    check_val("to_sticky", timeout_o, 1);
`endif

    // Reset in the middle of a drain.
    aw_valid_i = 1; aw_ready_i = 1; cyc();
    idle_bus();
    isolate_req_i = 1; cyc(); cyc();
    do_reset();

    // Random traffic with changing B/R return rates.
    bias = 1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) bias = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) isolate_req_i = ~isolate_req_i;
      aw_valid_i = $urandom_range(0, 1); aw_ready_i = $urandom_range(0, 1);
      ar_valid_i = $urandom_range(0, 1); ar_ready_i = $urandom_range(0, 1);
      b_valid_i  = ($urandom_range(0, 3) < bias); b_ready_i = $urandom_range(0, 1);
      r_valid_i  = ($urandom_range(0, 3) < bias); r_ready_i = $urandom_range(0, 1);
      r_last_i   = $urandom_range(0, 1);
      cyc();
      if (i == 900) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1);
  end

endmodule
